// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-aligned requests with byte enables,
// two-beat handling of misaligned accesses, load realignment and extension.
module load_store_unit #(
   parameter int ALLOW_SPLIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ls_valid,
   input  logic        ls_we,
   input  logic [2:0]  ls_funct3,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_stall,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_REQ1  = 3'd3,
      S_WAIT1 = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      r_state;

   logic [1:0]  w_off;
   logic [3:0]  w_mask;
   logic [7:0]  w_lanes;
   logic        w_split;
   logic        w_err;
   logic [63:0] w_wide;
   logic [31:0] w_base;

   // Per-access context latched on acceptance, used for beat 1 and load extension.
   logic [1:0]  r_off;
   logic [2:0]  r_f3;
   logic        r_we;
   logic        r_split;
   logic [31:0] r_addr1;
   logic [3:0]  r_be1;
   logic [31:0] r_wdata1;
   logic [31:0] r_rd0;

   assign w_off = ls_addr[1:0];

   always_comb begin
      case (ls_funct3[1:0])
         2'b00:   w_mask = 4'h1;
         2'b01:   w_mask = 4'h3;
         default: w_mask = 4'hF;
      endcase
   end

   assign w_lanes = {4'h0, w_mask} << w_off;
   assign w_split = |w_lanes[7:4];
   assign w_wide  = {32'h0, ls_wdata} << {w_off, 3'b000};
   assign w_base  = {ls_addr[31:2], 2'b00};
   assign w_err   = (ls_funct3[1:0] == 2'b11) | (ls_we & ls_funct3[2]) |
                    (w_split & (ALLOW_SPLIT == 0));

   assign ls_stall = !reset & (((r_state == S_IDLE) & ls_valid) |
                               (r_state == S_REQ0) | (r_state == S_WAIT0) |
                               (r_state == S_REQ1) | (r_state == S_WAIT1));

   // Realign the two-word window to the access offset, then extend.
   function automatic logic [31:0] f_extend(input logic [63:0] w,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
      logic [31:0] v;
      v = 32'(w >> {off, 3'b000});
      case (f3[1:0])
         2'b00:   f_extend = f3[2] ? {24'h0, v[7:0]}   : {{24{v[7]}}, v[7:0]};
         2'b01:   f_extend = f3[2] ? {16'h0, v[15:0]}  : {{16{v[15]}}, v[15:0]};
         default: f_extend = v;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         ls_done   <= 1'b0;
         ls_rdata  <= 32'h0;
         ls_err    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'h0;
         mem_wdata <= 32'h0;
         r_off     <= 2'b00;
         r_f3      <= 3'b000;
         r_we      <= 1'b0;
         r_split   <= 1'b0;
         r_addr1   <= 32'h0;
         r_be1     <= 4'h0;
         r_wdata1  <= 32'h0;
         r_rd0     <= 32'h0;
      end else begin
         ls_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ls_valid) begin
                  r_off    <= w_off;
                  r_f3     <= ls_funct3;
                  r_we     <= ls_we;
                  r_split  <= w_split;
                  r_addr1  <= w_base + 32'd4;
                  r_be1    <= w_lanes[7:4];
                  r_wdata1 <= w_wide[63:32];
                  if (w_err) begin
                     ls_done  <= 1'b1;
                     ls_err   <= 1'b1;
                     ls_rdata <= 32'h0;
                     r_state  <= S_DONE;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= ls_we;
                     mem_addr  <= w_base;
                     mem_be    <= w_lanes[3:0];
                     mem_wdata <= w_wide[31:0];
                     r_state   <= S_REQ0;
                  end
               end
            end
            S_REQ0: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  r_state <= S_WAIT0;
               end
            end
            S_WAIT0: begin
               if (mem_rvalid) begin
                  r_rd0 <= mem_rdata;
                  if (r_split) begin
                     mem_req   <= 1'b1;
                     mem_addr  <= r_addr1;
                     mem_be    <= r_be1;
                     mem_wdata <= r_wdata1;
                     r_state   <= S_REQ1;
                  end else begin
                     ls_done  <= 1'b1;
                     ls_err   <= 1'b0;
                     ls_rdata <= r_we ? 32'h0 : f_extend({32'h0, mem_rdata}, r_off, r_f3);
                     r_state  <= S_DONE;
                  end
               end
            end
            S_REQ1: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  r_state <= S_WAIT1;
               end
            end
            S_WAIT1: begin
               if (mem_rvalid) begin
                  ls_done  <= 1'b1;
                  ls_err   <= 1'b0;
                  ls_rdata <= r_we ? 32'h0 : f_extend({mem_rdata, r_rd0}, r_off, r_f3);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
